uart_rx_param: RTL

Parametrised UART receiver for the flight-software bitstream. Successor to the fixed 8N1 receiver, with configurable data width, parity and stop bits, a 3-sample majority vote per bit, and an input synchroniser. Received bytes are reported with a stretched save strobe and a wrapping write pointer that indexes the downstream byte buffer. Parity and framing errors are flagged, and errored bytes are never saved.

---
 rtl/uart_rx_param.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, stretched save strobe and wrapping write pointer.
module uart_rx_param #(
   parameter int unsigned CLKS_PER_BIT   = 50,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned PARITY_MODE    = 0,
   parameter int unsigned STOP_BITS      = 1,
   parameter int unsigned PTR_WIDTH      = 13,
   parameter int unsigned SAVE_PULSE_LEN = 7
) (
   input  logic                 i_Clock,
   input  logic                 RESET,
   input  logic                 EN,
   input  logic                 i_RX_Serial,
   output logic [2:0]           o_state,
   output logic [DATA_BITS-1:0] o_rx_byte,
   output logic [PTR_WIDTH-1:0] o_write_pointer,
   output logic                 o_save_byte,
   output logic                 o_parity_err,
   output logic                 o_frame_err
);

   localparam int unsigned CNT_MAX = (CLKS_PER_BIT > SAVE_PULSE_LEN) ? CLKS_PER_BIT : SAVE_PULSE_LEN;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
   localparam int unsigned MID     = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] SMP_0     = CNT_W'(MID - 1);
   localparam logic [CNT_W-1:0] SMP_1     = CNT_W'(MID);
   localparam logic [CNT_W-1:0] SMP_2     = CNT_W'(MID + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SAVE_LAST = CNT_W'(SAVE_PULSE_LEN - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      SAVE   = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [2:0]           smp_q, smp_d;
   logic [DATA_BITS-1:0] shadow_q, shadow_d;
   logic                 par_err_q, par_err_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
   logic                 save_q, save_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;

   logic sync1_q, line_q, line_prev_q;
   logic fall, bit_done, maj, in_bit;

   // Metastability synchroniser plus one cycle of line history for edge detection
   always_ff @(posedge i_Clock) begin
      if (RESET) begin
         sync1_q     <= 1'b1;
         line_q      <= 1'b1;
         line_prev_q <= 1'b1;
      end else begin
         sync1_q     <= i_RX_Serial;
         line_q      <= sync1_q;
         line_prev_q <= line_q;
      end
   end

   assign fall     = line_prev_q & ~line_q;
   assign bit_done = (clk_cnt_q == BIT_LAST);
   assign in_bit   = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

   always_ff @(posedge i_Clock) begin
      if (RESET) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         smp_q     <= 3'b111;
         shadow_q  <= '0;
         par_err_q <= 1'b0;
         rx_byte_q <= '0;
         ptr_q     <= '0;
         save_q    <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         smp_q     <= smp_d;
         shadow_q  <= shadow_d;
         par_err_q <= par_err_d;
         rx_byte_q <= rx_byte_d;
         ptr_q     <= ptr_d;
         save_q    <= save_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      smp_d     = smp_q;
      shadow_d  = shadow_q;
      par_err_d = par_err_q;
      rx_byte_d = rx_byte_q;
      ptr_d     = ptr_q;
      save_d    = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;

      // The third sample may coincide with the evaluation cycle, so vote on the next-state copy
      if (in_bit) begin
         if (clk_cnt_q == SMP_0) smp_d[0] = line_q;
         if (clk_cnt_q == SMP_1) smp_d[1] = line_q;
         if (clk_cnt_q == SMP_2) smp_d[2] = line_q;
         clk_cnt_d = bit_done ? '0 : clk_cnt_q + CNT_W'(1);
      end
      maj = (smp_d[0] & smp_d[1]) | (smp_d[0] & smp_d[2]) | (smp_d[1] & smp_d[2]);

      case (state_q)
         IDLE: begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            if (fall) begin
               state_d   = START;
               shadow_d  = '0;
               par_err_d = 1'b0;
            end
         end
         START: begin
            if (bit_done) state_d = maj ? IDLE : DATA;
         end
         DATA: begin
            if (bit_done) begin
               shadow_d = {maj, shadow_q[DATA_BITS-1:1]};
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            // Total ones (data + parity) must be odd in odd mode, even in even mode
            if (bit_done) begin
               if ((^shadow_q ^ maj) != (PARITY_MODE == 1)) par_err_d = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!maj) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end else if (bit_cnt_q == STOP_LAST) begin
                  if (par_err_q) begin
                     perr_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d   = SAVE;
                     rx_byte_d = shadow_q;
                     save_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         SAVE: begin
            if (clk_cnt_q == SAVE_LAST) begin
               state_d   = IDLE;
               clk_cnt_d = '0;
               ptr_d     = ptr_q + PTR_WIDTH'(1);
            end else begin
               save_d    = 1'b1;
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Disable discards any partial frame but keeps the last good word and pointer
      if (!EN) begin
         state_d   = IDLE;
         clk_cnt_d = '0;
         bit_cnt_d = '0;
         rx_byte_d = rx_byte_q;
         ptr_d     = ptr_q;
         save_d    = 1'b0;
         perr_d    = 1'b0;
         ferr_d    = 1'b0;
      end
   end

   assign o_state         = state_q;
   assign o_rx_byte       = rx_byte_q;
   assign o_write_pointer = ptr_q;
   assign o_save_byte     = save_q;
   assign o_parity_err    = perr_q;
   assign o_frame_err     = ferr_q;

endmodule
